// File: rtl/rr_onehot_arb_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
interface rr_onehot_arb_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       busy;
  logic       timeout;

  // Requester side: raises requests and signals release.
  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_idx,
    input  busy,
    input  timeout
  );

  // Arbiter side.
  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_idx,
    output busy,
    output timeout
  );
endinterface

// File: rtl/rr_onehot_arb.sv
// Eight-way round-robin arbiter with one-hot grant, hold-time limit and
// a mandatory one-cycle idle turnaround between grants.
module rr_onehot_arb #(
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic           clk,
  input  logic           rst,
  rr_onehot_arb_if.slave bus
);

  localparam int unsigned N_REQ  = 8;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned HOLD_W = 8;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic [IDX_W-1:0]    gnt_idx_q, gnt_idx_d;
  logic                busy_q, busy_d;
  logic                timeout_q, timeout_d;

  logic [IDX_W-1:0]    pick_idx_c;
  logic                any_req_c;
  logic                normal_rel_c;
  logic                expire_c;
  logic                release_c;

  // First requester in search order ptr, ptr+1, ..., ptr+7.
  always_comb begin
    pick_idx_c = ptr_q;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req[ptr_q + IDX_W'(i)]) pick_idx_c = ptr_q + IDX_W'(i);
    end
  end

  // Release qualifiers for the active grant.
  always_comb begin
    any_req_c    = |bus.req;
    normal_rel_c = bus.done || !bus.req[gnt_idx_q];
    expire_c     = (hold_q == HOLD_W'(MAX_HOLD - 1));
    release_c    = (state_q == GRANT) && (normal_rel_c || expire_c);
  end

  // State and output registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      hold_q    <= '0;
      gnt_q     <= '0;
      gnt_idx_q <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      gnt_q     <= gnt_d;
      gnt_idx_q <= gnt_idx_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req_c) state_d = GRANT;
      GRANT:   if (release_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs, pointer and hold counter.
  always_comb begin
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    gnt_d     = gnt_q;
    gnt_idx_d = gnt_idx_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        gnt_d  = '0;
        busy_d = 1'b0;
        if (any_req_c) begin
          gnt_idx_d = pick_idx_c;
          gnt_d     = N_REQ'(1) << pick_idx_c;
          busy_d    = 1'b1;
          hold_d    = '0;
        end
      end
      GRANT: begin
        if (release_c) begin
          gnt_d     = '0;
          busy_d    = 1'b0;
          ptr_d     = gnt_idx_q + IDX_W'(1);
          timeout_d = expire_c && !normal_rel_c;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: begin
        gnt_d  = '0;
        busy_d = 1'b0;
      end
    endcase
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_idx = gnt_idx_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_rr_onehot_arb.sv
// Directed bench for rr_onehot_arb: rotation, wrap, timeout, req drop,
// mid-grant reset and done/expiry collision.
module tb_rr_onehot_arb;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  rr_onehot_arb_if bus ();

  rr_onehot_arb #(.MAX_HOLD(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs are driven and outputs sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = 8'h00;
    bus.done = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (bus.gnt !== 8'h00) begin n_err++; $display("FAIL reset_gnt got %h want 00", bus.gnt); end
    n_cmp++;
    if (bus.gnt_idx !== 3'd0) begin n_err++; $display("FAIL reset_idx got %0d want 0", bus.gnt_idx); end
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.timeout !== 1'b0) begin
      n_err++; $display("FAIL reset_flags got busy=%b timeout=%b want 0 0", bus.busy, bus.timeout);
    end
  endtask

  task automatic test_rotation();
    logic [7:0] exp_gnt [9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    logic [2:0] exp_idx [9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    do_reset();
    bus.req = 8'hFF;
    tick();
    for (int k = 0; k < 9; k++) begin
      n_cmp++;
      if (bus.gnt !== exp_gnt[k] || bus.gnt_idx !== exp_idx[k] || bus.busy !== 1'b1) begin
        n_err++;
        $display("FAIL rotation_grant[%0d] got gnt=%h idx=%0d busy=%b want gnt=%h idx=%0d busy=1",
                 k, bus.gnt, bus.gnt_idx, bus.busy, exp_gnt[k], exp_idx[k]);
      end
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
      n_cmp++;
      if (bus.gnt !== 8'h00 || bus.busy !== 1'b0) begin
        n_err++; $display("FAIL rotation_gap[%0d] got gnt=%h busy=%b want 00 0", k, bus.gnt, bus.busy);
      end
      tick();
    end
    bus.req = 8'h00;
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    bus.req = 8'h10;
    tick();
    n_cmp++;
    if (bus.gnt !== 8'h10) begin n_err++; $display("FAIL wrap_first got %h want 10", bus.gnt); end
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    bus.req = 8'h05;
    tick();
    n_cmp++;
    if (bus.gnt !== 8'h01 || bus.gnt_idx !== 3'd0) begin
      n_err++; $display("FAIL wrap_grant got gnt=%h idx=%0d want 01 0", bus.gnt, bus.gnt_idx);
    end
  endtask

  task automatic test_timeout();
    int held;
    do_reset();
    bus.req = 8'h08;
    tick();
    held = 0;
    for (int c = 0; c < 15; c++) begin
      if (bus.gnt === 8'h08 && bus.timeout === 1'b0) held++;
      if (c < 14) tick();
    end
    n_cmp++;
    if (held != 15) begin n_err++; $display("FAIL timeout_hold got %0d cycles want 15", held); end
    tick();
    n_cmp++;
    if (bus.gnt !== 8'h00 || bus.timeout !== 1'b1 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL timeout_pulse got gnt=%h timeout=%b busy=%b want 00 1 0",
                        bus.gnt, bus.timeout, bus.busy);
    end
    bus.req = 8'h18;
    tick();
    n_cmp++;
    if (bus.gnt !== 8'h10 || bus.gnt_idx !== 3'd4 || bus.timeout !== 1'b0) begin
      n_err++; $display("FAIL timeout_next got gnt=%h idx=%0d timeout=%b want 10 4 0",
                        bus.gnt, bus.gnt_idx, bus.timeout);
    end
  endtask

  task automatic test_req_drop();
    do_reset();
    bus.req = 8'h04;
    tick();
    bus.req = 8'hF4;
    tick();
    n_cmp++;
    if (bus.gnt !== 8'h04) begin n_err++; $display("FAIL other_req_change got %h want 04", bus.gnt); end
    bus.req = 8'h00;
    tick();
    n_cmp++;
    if (bus.gnt !== 8'h00 || bus.timeout !== 1'b0) begin
      n_err++; $display("FAIL req_drop got gnt=%h timeout=%b want 00 0", bus.gnt, bus.timeout);
    end
    bus.req = 8'h0C;
    tick();
    n_cmp++;
    if (bus.gnt !== 8'h08 || bus.gnt_idx !== 3'd3) begin
      n_err++; $display("FAIL req_drop_ptr got gnt=%h idx=%0d want 08 3", bus.gnt, bus.gnt_idx);
    end
  endtask

  task automatic test_rst_mid();
    do_reset();
    bus.req = 8'h40;
    tick();
    n_cmp++;
    if (bus.gnt !== 8'h40) begin n_err++; $display("FAIL rst_mid_setup got %h want 40", bus.gnt); end
    rst = 1'b1;
    bus.req = 8'h41;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (bus.gnt !== 8'h00 || bus.busy !== 1'b0 || bus.gnt_idx !== 3'd0 || bus.timeout !== 1'b0) begin
      n_err++; $display("FAIL rst_mid got gnt=%h busy=%b idx=%0d timeout=%b want 00 0 0 0",
                        bus.gnt, bus.busy, bus.gnt_idx, bus.timeout);
    end
    tick();
    n_cmp++;
    if (bus.gnt !== 8'h01 || bus.gnt_idx !== 3'd0) begin
      n_err++; $display("FAIL rst_first_grant got gnt=%h idx=%0d want 01 0", bus.gnt, bus.gnt_idx);
    end
  endtask

  task automatic test_done_expiry();
    do_reset();
    bus.req = 8'h02;
    tick();
    for (int c = 0; c < 14; c++) tick();
    n_cmp++;
    if (bus.gnt !== 8'h02) begin n_err++; $display("FAIL collide_held got %h want 02", bus.gnt); end
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    n_cmp++;
    if (bus.gnt !== 8'h00 || bus.timeout !== 1'b0) begin
      n_err++; $display("FAIL collide_release got gnt=%h timeout=%b want 00 0", bus.gnt, bus.timeout);
    end
    bus.req = 8'h00;
    tick();
    bus.done = 1'b1;
    tick();
    n_cmp++;
    if (bus.gnt !== 8'h00 || bus.busy !== 1'b0 || bus.timeout !== 1'b0) begin
      n_err++; $display("FAIL idle_done got gnt=%h busy=%b timeout=%b want 00 0 0",
                        bus.gnt, bus.busy, bus.timeout);
    end
    bus.req = 8'h01;
    tick();
    bus.done = 1'b0;
    n_cmp++;
    if (bus.gnt !== 8'h01) begin n_err++; $display("FAIL idle_done_grant got %h want 01", bus.gnt); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.req = 8'h00;
    bus.done = 1'b0;
    test_reset();
    test_rotation();
    test_wrap();
    test_timeout();
    test_req_drop();
    test_rst_mid();
    test_done_expiry();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
